// File: rtl/game_timer_ctrl_pkg.sv
// Shared types and helpers for the game timer: state encoding, BCD digit pair
// and the countdown step used by the timer datapath.
package game_timer_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PAUSE   = 2'd2,
        EXPIRED = 2'd3
    } state_e;

    localparam logic [3:0] BCD_MAX  = 4'd9;
    localparam logic [3:0] BCD_ZERO = 4'd0;

    typedef struct packed {
        logic [3:0] tens;
        logic [3:0] ones;
    } bcd2_t;

    // Counter width for a modulo-div counter; never narrower than one bit.
    function automatic int cnt_width(input int div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

    // Two-digit BCD decrement with borrow from tens. Callers never apply it to 00.
    function automatic bcd2_t bcd_dec(input bcd2_t v);
        bcd2_t r;
        r = v;
        if (v.ones == BCD_ZERO) begin
            r.ones = BCD_MAX;
            r.tens = v.tens - 4'd1;
        end else begin
            r.ones = v.ones - 4'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/game_timer_ctrl_sec_tick_gen.sv
// One-second prescaler: counts only while enabled, freezes otherwise, and emits
// a registered single-cycle SecTick when it wraps from TICK_DIV-1 to 0.
module sec_tick_gen
    import game_timer_ctrl_pkg::*;
#(
    parameter int TICK_DIV = 50000000
) (
    input  logic Clk,
    input  logic Rst,
    input  logic Count_En,
    input  logic Sync_Clr,
    output logic SecTick
);

    localparam int              CNT_W = cnt_width(TICK_DIV);
    localparam logic [CNT_W-1:0] TERM = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic             tick_d, tick_q;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        cnt_d  = cnt_q;
        tick_d = 1'b0;
        if (Sync_Clr) begin
            cnt_d = '0;
        end else if (Count_En) begin
            if (cnt_q == TERM) begin
                cnt_d  = '0;
                tick_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // NOTE: state flops use non-blocking assignments and an asynchronous active-low reset.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign SecTick = tick_q;

endmodule

// File: rtl/game_timer_ctrl.sv
// Countdown timer and score/timer display select: start/pause/clear FSM,
// two-digit BCD countdown and Enable alternation, all outputs registered.
module game_timer_ctrl
    import game_timer_ctrl_pkg::*;
#(
    parameter int TICK_DIV   = 50000000,
    parameter int START_TENS = 6,
    parameter int START_ONES = 0,
    parameter int TIMER_SHOW = 4,
    parameter int SCORE_SHOW = 2
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       Start,
    input  logic       Pause,
    input  logic       Clear,
    output logic [3:0] second,
    output logic [3:0] first,
    output logic       Enable,
    output logic       SecTick,
    output logic       Running,
    output logic       Expired
);

    localparam int               DISP_W    = cnt_width(TIMER_SHOW + SCORE_SHOW);
    localparam logic [DISP_W-1:0] DISP_LAST = DISP_W'(TIMER_SHOW + SCORE_SHOW - 1);
    localparam logic [DISP_W-1:0] DISP_SCORE = DISP_W'(TIMER_SHOW);
    localparam bcd2_t             START_VAL = {4'(START_TENS), 4'(START_ONES)};

    state_e              state_d, state_q;
    bcd2_t               bcd_d, bcd_q;
    logic [DISP_W-1:0]   disp_d, disp_q, disp_inc;
    logic                enable_d, enable_q;
    logic                running_d, running_q;
    logic                expired_d, expired_q;
    logic                sec_tick;
    logic                resync;
    logic                dec_en;
    logic                last_sec;

    // The prescaler restarts on a fresh Start or any Clear, and runs only in RUN.
    assign resync   = Clear || ((state_q == IDLE) && Start);
    assign dec_en   = sec_tick && (state_q == RUN);
    assign last_sec = (bcd_q.tens == BCD_ZERO) && (bcd_q.ones == 4'd1);

    sec_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_sec_tick_gen (
        .Clk      (Clk),
        .Rst      (Rst),
        .Count_En (state_q == RUN),
        .Sync_Clr (resync),
        .SecTick  (sec_tick)
    );

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q   <= IDLE;
            bcd_q     <= START_VAL;
            disp_q    <= '0;
            enable_q  <= 1'b0;
            running_q <= 1'b0;
            expired_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            bcd_q     <= bcd_d;
            disp_q    <= disp_d;
            enable_q  <= enable_d;
            running_q <= running_d;
            expired_q <= expired_d;
        end
    end

    // Clear beats everything; the tick reaching 00 beats a coincident Pause.
    always_comb begin
        state_d = state_q;
        if (Clear) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE:    if (Start) state_d = RUN;
                RUN: begin
                    if (dec_en && last_sec) state_d = EXPIRED;
                    else if (Pause)         state_d = PAUSE;
                end
                PAUSE:   if (Pause) state_d = RUN;
                EXPIRED: state_d = EXPIRED;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        bcd_d    = bcd_q;
        disp_d   = disp_q;
        enable_d = enable_q;
        disp_inc = (disp_q == DISP_LAST) ? '0 : disp_q + DISP_W'(1);
        if (resync) begin
            bcd_d    = START_VAL;
            disp_d   = '0;
            enable_d = 1'b0;
        end else if (dec_en) begin
            bcd_d    = bcd_dec(bcd_q);
            disp_d   = disp_inc;
            enable_d = (disp_inc >= DISP_SCORE);
        end
        if (state_d == EXPIRED) enable_d = 1'b1;
        running_d = (state_d == RUN);
        expired_d = (state_d == EXPIRED);
    end

    assign second  = bcd_q.tens;
    assign first   = bcd_q.ones;
    assign Enable  = enable_q;
    assign SecTick = sec_tick;
    assign Running = running_q;
    assign Expired = expired_q;

endmodule

// File: tb/tb_game_timer_ctrl.sv
// Bench for game_timer_ctrl: two instances (start 03 and start 10) share one
// stimulus stream; a seconds-level model is compared every cycle plus literal checks.
module tb_game_timer_ctrl;

    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_EXP = 3;
    localparam int P_TD [2] = '{4, 4};
    localparam int P_ST [2] = '{3, 10};
    localparam int P_TS [2] = '{1, 2};
    localparam int P_SS [2] = '{1, 1};

    typedef struct {
        int mode;
        int rem;
        int phase;
        int ticks;
        bit pulse;
    } mdl_t;

    logic       clk = 1'b0, rst_n = 1'b1;
    logic       start = 1'b0, pause = 1'b0, clear = 1'b0;
    logic [3:0] sec_a, fir_a, sec_b, fir_b;
    logic       en_a, tk_a, run_a, exp_a, en_b, tk_b, run_b, exp_b;
    int         checks = 0, errors = 0, cyc = 0;
    int         t0, tr;
    int         n;
    mdl_t       m [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    game_timer_ctrl #(
        .TICK_DIV(4), .START_TENS(0), .START_ONES(3), .TIMER_SHOW(1), .SCORE_SHOW(1)
    ) dut_a (
        .Clk(clk), .Rst(rst_n), .Start(start), .Pause(pause), .Clear(clear),
        .second(sec_a), .first(fir_a), .Enable(en_a), .SecTick(tk_a),
        .Running(run_a), .Expired(exp_a)
    );

    game_timer_ctrl #(
        .TICK_DIV(4), .START_TENS(1), .START_ONES(0), .TIMER_SHOW(2), .SCORE_SHOW(1)
    ) dut_b (
        .Clk(clk), .Rst(rst_n), .Start(start), .Pause(pause), .Clear(clear),
        .second(sec_b), .first(fir_b), .Enable(en_b), .SecTick(tk_b),
        .Running(run_b), .Expired(exp_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: remaining time as a plain integer, seconds counted since Start.
    function automatic mdl_t mdl_reset(input int k);
        mdl_t r;
        r.mode = M_IDLE; r.rem = P_ST[k]; r.phase = 0; r.ticks = 0; r.pulse = 1'b0;
        return r;
    endfunction

    function automatic mdl_t mdl_step(input mdl_t s, input int k, input logic st, input logic pa, input logic cl);
        mdl_t n2;
        logic resync, dec;
        n2     = s;
        resync = cl || (s.mode == M_IDLE && st);
        dec    = s.pulse && (s.mode == M_RUN) && !cl;
        n2.pulse = !resync && (s.mode == M_RUN) && (s.phase == P_TD[k] - 1);
        if (resync)               n2.phase = 0;
        else if (s.mode == M_RUN) n2.phase = (s.phase + 1) % P_TD[k];
        if (cl) begin
            n2.mode = M_IDLE; n2.rem = P_ST[k]; n2.ticks = 0;
        end else begin
            case (s.mode)
                M_IDLE:  if (st) begin n2.mode = M_RUN; n2.ticks = 0; end
                M_RUN: begin
                    if (dec) begin n2.rem = s.rem - 1; n2.ticks = s.ticks + 1; end
                    if (n2.rem == 0) n2.mode = M_EXP;
                    else if (pa)     n2.mode = M_PAUSE;
                end
                M_PAUSE: if (pa) n2.mode = M_RUN;
                default: ;
            endcase
        end
        return n2;
    endfunction

    function automatic logic [11:0] mdl_out(input mdl_t s, input int k);
        logic en;
        if (s.mode == M_EXP)       en = 1'b1;
        else if (s.mode == M_IDLE) en = 1'b0;
        else                       en = (s.ticks % (P_TS[k] + P_SS[k])) >= P_TS[k];
        return {4'(s.rem / 10), 4'(s.rem % 10), en, s.pulse, s.mode == M_RUN, s.mode == M_EXP};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) m[k] <= mdl_reset(k);
            else        m[k] <= mdl_step(m[k], k, start, pause, clear);
        end
    end

    always @(negedge clk) begin
        check("cycle_a", {20'd0, sec_a, fir_a, en_a, tk_a, run_a, exp_a}, {20'd0, mdl_out(m[0], 0)});
        check("cycle_b", {20'd0, sec_b, fir_b, en_b, tk_b, run_b, exp_b}, {20'd0, mdl_out(m[1], 1)});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic s, input logic p, input logic c);
        start = s; pause = p; clear = c;
        tick();
        start = 1'b0; pause = 1'b0; clear = 1'b0;
    endtask

    task automatic wait_tick();
        for (int i = 0; i < 40; i++) begin
            tick();
            if (tk_a) return;
        end
        check("sectick_timeout", {31'd0, tk_a}, 32'd1);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        check("rst_digits", {sec_a, fir_a}, 8'h03);
        check("rst_flags", {en_a, tk_a, run_a, exp_a}, 4'b0000);
        check("rst_digits_b", {sec_b, fir_b}, 8'h10);

        // Full countdown 03 -> 00 with Enable alternation; dut_b borrows 10 -> 09 -> 08.
        pulse(1'b1, 1'b0, 1'b0);
        t0 = cyc;
        check("running_rise", run_a, 1);
        wait_tick();
        check("tick1_latency", cyc - t0, 4);
        tr = cyc;
        tick();
        check("t1_digits", {sec_a, fir_a}, 8'h02);
        check("t1_enable", en_a, 1);
        check("b_borrow1", {sec_b, fir_b}, 8'h09);
        wait_tick();
        check("tick2_gap", cyc - tr, 4);
        tr = cyc;
        tick();
        check("t2_digits", {sec_a, fir_a}, 8'h01);
        check("t2_enable", en_a, 0);
        check("b_borrow2", {sec_b, fir_b}, 8'h08);
        wait_tick();
        check("tick3_gap", cyc - tr, 4);
        tick();
        check("exp_digits", {sec_a, fir_a}, 8'h00);
        check("exp_flags", {en_a, run_a, exp_a}, 3'b101);
        n = 0;
        repeat (10) begin tick(); n += int'(tk_a); end
        check("no_tick_expired", n, 0);

        // Start/Pause ignored in EXPIRED; Clear reloads.
        pulse(1'b1, 1'b0, 1'b0);
        pulse(1'b0, 1'b1, 1'b0);
        check("exp_hold", {sec_a, fir_a, en_a, run_a, exp_a}, {8'h00, 3'b101});
        pulse(1'b0, 1'b0, 1'b1);
        check("clear_digits", {sec_a, fir_a}, 8'h03);
        check("clear_flags", {en_a, run_a, exp_a}, 3'b000);

        // Priority: Start beats Pause in IDLE; Clear beats Start in RUN.
        pulse(1'b1, 1'b1, 1'b0);
        check("start_over_pause", run_a, 1);
        repeat (5) tick();
        pulse(1'b1, 1'b0, 1'b1);
        check("clear_over_start", {sec_a, fir_a, run_a}, {8'h03, 1'b0});

        // Pause after two prescaler cycles; the partial second survives.
        pulse(1'b1, 1'b0, 1'b0);
        tick();
        pulse(1'b0, 1'b1, 1'b0);
        check("paused", run_a, 0);
        n = 0;
        repeat (10) begin tick(); n += int'(tk_a); end
        check("no_tick_paused", n, 0);
        check("pause_enable_hold", en_a, 0);
        pulse(1'b0, 1'b1, 1'b0);
        tr = cyc;
        wait_tick();
        check("resume_tick_gap", cyc - tr, 2);
        pulse(1'b0, 1'b0, 1'b1);

        // Asynchronous reset between clock edges mid-countdown.
        pulse(1'b1, 1'b0, 1'b0);
        wait_tick();
        tick();
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_digits", {sec_a, fir_a}, 8'h03);
        check("async_rst_flags", {en_a, tk_a, run_a, exp_a}, 4'b0000);
        #3 rst_n = 1'b1;
        tick();
        pulse(1'b1, 1'b0, 1'b0);
        t0 = cyc;
        wait_tick();
        check("post_rst_latency", cyc - t0, 4);
        check("post_rst_digits", {sec_a, fir_a}, 8'h03);
        tick();
        check("post_rst_dec", {sec_a, fir_a}, 8'h02);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
